// File: rtl/single_cycle_cpu.sv
// Single-cycle RV32I-subset CPU: PC, instruction ROM, register file, ALU and data RAM.
// Define CPU_MUL_EN to build the R-type mul instruction; otherwise its encoding is a NOP.

module program_counter #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_next_pc,
  output logic [31:0] pc_out
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) pc_out <= RESET_PC;
    else          pc_out <= i_next_pc;
endmodule

module imem #(
  parameter int    WORDS = 64,
  parameter string FILE  = "program.hex"
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_data
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  logic [31:0]   ROM [0:WORDS-1];
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = AW'({2'b00, i_addr[31:2]} % WORDS);
  assign w_unused = ^i_addr[1:0];
  assign o_data   = ROM[w_idx];
endmodule

module reg_file (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] register [0:31];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) for (int i = 0; i < 32; i++) register[i] <= '0;
    else if (i_we && i_rd != 5'd0) register[i_rd] <= i_wd;

  assign o_rd1 = (i_rs1 == 5'd0) ? '0 : register[i_rs1];
  assign o_rd2 = (i_rs2 == 5'd0) ? '0 : register[i_rs2];
endmodule

module dmem #(
  parameter int WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  logic [31:0]   RAM [0:WORDS-1];
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_idx    = AW'({2'b00, i_addr[31:2]} % WORDS);
  assign w_unused = ^i_addr[1:0];
  assign o_rd     = RAM[w_idx];

  always_ff @(posedge i_clk)
    if (i_we) RAM[w_idx] <= i_wd;
endmodule

module single_cycle_cpu #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [31:0] w_pc, w_next_pc, instruction;
  logic [31:0] w_rs1_val, w_rs2_val, w_wd, w_addr, w_ld_data, w_pc4;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_we, w_mem_we, w_take;

  program_counter #(.RESET_PC(RESET_PC)) program_counter_u (
    .i_clk(clk), .i_rst_n(reset), .i_next_pc(w_next_pc), .pc_out(w_pc));

  imem #(.WORDS(IMEM_WORDS), .FILE(IMEM_FILE)) imem_u (
    .i_addr(w_pc), .o_data(instruction));

  reg_file reg_file_u (
    .i_clk(clk), .i_rst_n(reset), .i_we(w_we), .i_rs1(w_rs1), .i_rs2(w_rs2),
    .i_rd(w_rd), .i_wd(w_wd), .o_rd1(w_rs1_val), .o_rd2(w_rs2_val));

  // The store is gated by reset so an instruction caught by reset leaves RAM untouched.
  dmem #(.WORDS(DMEM_WORDS)) dmem_u (
    .i_clk(clk), .i_we(w_mem_we & reset), .i_addr(w_addr), .i_wd(w_rs2_val), .o_rd(w_ld_data));

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_funct3 = instruction[14:12];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];
  assign w_funct7 = instruction[31:25];
  assign w_pc4    = w_pc + 32'd4;

  assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_imm_u = {instruction[31:12], 12'b0};
  assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    w_next_pc = w_pc4;
    w_we      = 1'b0;
    w_wd      = '0;
    w_mem_we  = 1'b0;
    w_take    = 1'b0;
    w_addr    = w_rs1_val + w_imm_i;
    case (w_opcode)
      OP_R: begin
        w_we = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_wd = w_rs1_val + w_rs2_val;
          {7'b0100000, 3'b000}: w_wd = w_rs1_val - w_rs2_val;
          {7'b0000000, 3'b111}: w_wd = w_rs1_val & w_rs2_val;
          {7'b0000000, 3'b110}: w_wd = w_rs1_val | w_rs2_val;
          {7'b0000000, 3'b100}: w_wd = w_rs1_val ^ w_rs2_val;
          {7'b0000000, 3'b010}: w_wd = {31'b0, $signed(w_rs1_val) < $signed(w_rs2_val)};
          {7'b0000000, 3'b001}: w_wd = w_rs1_val << w_rs2_val[4:0];
          {7'b0000000, 3'b101}: w_wd = w_rs1_val >> w_rs2_val[4:0];
          {7'b0100000, 3'b101}: w_wd = $unsigned($signed(w_rs1_val) >>> w_rs2_val[4:0]);
`ifdef CPU_MUL_EN
          {7'b0000001, 3'b000}: w_wd = w_rs1_val * w_rs2_val;
`endif
          default:              w_we = 1'b0;
        endcase
      end
      OP_I: begin
        w_we = 1'b1;
        case (w_funct3)
          3'b000:  w_wd = w_rs1_val + w_imm_i;
          3'b111:  w_wd = w_rs1_val & w_imm_i;
          3'b110:  w_wd = w_rs1_val | w_imm_i;
          3'b010:  w_wd = {31'b0, $signed(w_rs1_val) < $signed(w_imm_i)};
          default: w_we = 1'b0;
        endcase
      end
      OP_LW: if (w_funct3 == 3'b010) begin
        w_we = 1'b1;
        w_wd = w_ld_data;
      end
      OP_SW: if (w_funct3 == 3'b010) begin
        w_mem_we = 1'b1;
        w_addr   = w_rs1_val + w_imm_s;
      end
      OP_BR: begin
        case (w_funct3)
          3'b000:  w_take = (w_rs1_val == w_rs2_val);
          3'b001:  w_take = (w_rs1_val != w_rs2_val);
          3'b100:  w_take = ($signed(w_rs1_val) <  $signed(w_rs2_val));
          3'b101:  w_take = ($signed(w_rs1_val) >= $signed(w_rs2_val));
          default: w_take = 1'b0;
        endcase
        if (w_take) w_next_pc = w_pc + w_imm_b;
      end
      OP_LUI: begin
        w_we = 1'b1;
        w_wd = w_imm_u;
      end
      OP_JAL: begin
        w_we      = 1'b1;
        w_wd      = w_pc4;
        w_next_pc = w_pc + w_imm_j;
      end
      OP_JALR: if (w_funct3 == 3'b000) begin
        w_we      = 1'b1;
        w_wd      = w_pc4;
        w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed checks plus random programs compared against an ISA-level model.

module tb_single_cycle_cpu;
  localparam int IW = 64;
  localparam int DW = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CPU_MUL_EN
  localparam logic [31:0] EXP_MUL = 32'd30;
`else
  localparam logic [31:0] EXP_MUL = 32'd9;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  single_cycle_cpu #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_FILE(""), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_x   [32];
  logic [31:0] ref_mem [DW];
  logic [31:0] ref_rom [IW];
  logic [31:0] ref_pc;
  logic [31:0] prog [$];

  typedef enum {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA, M_MUL,
                M_ADDI, M_ANDI, M_ORI, M_SLTI, M_LW, M_SW,
                M_BEQ, M_BNE, M_BLT, M_BGE, M_LUI, M_JAL, M_JALR, M_NOP} mn_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rs1, rs2);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
  endfunction

  // ---------------- reference model ----------------
  function automatic mn_e decode(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd0}: return M_ADD;
        {7'h20, 3'd0}: return M_SUB;
        {7'h00, 3'd7}: return M_AND;
        {7'h00, 3'd6}: return M_OR;
        {7'h00, 3'd4}: return M_XOR;
        {7'h00, 3'd2}: return M_SLT;
        {7'h00, 3'd1}: return M_SLL;
        {7'h00, 3'd5}: return M_SRL;
        {7'h20, 3'd5}: return M_SRA;
`ifdef CPU_MUL_EN
        {7'h01, 3'd0}: return M_MUL;
`endif
        default:       return M_NOP;
      endcase
      7'b0010011: case (ins[14:12])
        3'd0: return M_ADDI;
        3'd7: return M_ANDI;
        3'd6: return M_ORI;
        3'd2: return M_SLTI;
        default: return M_NOP;
      endcase
      7'b0000011: return (ins[14:12] == 3'd2) ? M_LW : M_NOP;
      7'b0100011: return (ins[14:12] == 3'd2) ? M_SW : M_NOP;
      7'b1100011: case (ins[14:12])
        3'd0: return M_BEQ;
        3'd1: return M_BNE;
        3'd4: return M_BLT;
        3'd5: return M_BGE;
        default: return M_NOP;
      endcase
      7'b0110111: return M_LUI;
      7'b1101111: return M_JAL;
      7'b1100111: return (ins[14:12] == 3'd0) ? M_JALR : M_NOP;
      default:    return M_NOP;
    endcase
  endfunction

  task automatic ref_step();
    logic [31:0] ins, a, b, ii, is, ib, ij, wv, nxt;
    logic [4:0]  rd;
    logic        wr;
    mn_e         m;
    ins = ref_rom[ref_pc[31:2] % IW];
    m   = decode(ins);
    rd  = ins[11:7];
    a   = ref_x[ins[19:15]];
    b   = ref_x[ins[24:20]];
    ii  = $signed(ins) >>> 20;
    is  = (ii & ~32'h1f) | {27'b0, ins[11:7]};
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = ref_pc + 4;
    wr  = 1'b1;
    wv  = 32'h0;
    case (m)
      M_ADD:  wv = a + b;
      M_SUB:  wv = a - b;
      M_AND:  wv = a & b;
      M_OR:   wv = a | b;
      M_XOR:  wv = a ^ b;
      M_SLT:  wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      M_SLL:  wv = a << b[4:0];
      M_SRL:  wv = a >> b[4:0];
      M_SRA:  wv = $signed(a) >>> b[4:0];
      M_MUL:  wv = a * b;
      M_ADDI: wv = a + ii;
      M_ANDI: wv = a & ii;
      M_ORI:  wv = a | ii;
      M_SLTI: wv = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
      M_LW:   wv = ref_mem[((a + ii) >> 2) % DW];
      M_LUI:  wv = {ins[31:12], 12'h000};
      M_JAL:  begin wv = ref_pc + 4; nxt = ref_pc + ij; end
      M_JALR: begin wv = ref_pc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      M_SW:   begin wr = 1'b0; ref_mem[((a + is) >> 2) % DW] = b; end
      M_BEQ:  begin wr = 1'b0; if (a == b) nxt = ref_pc + ib; end
      M_BNE:  begin wr = 1'b0; if (a != b) nxt = ref_pc + ib; end
      M_BLT:  begin wr = 1'b0; if ($signed(a) <  $signed(b)) nxt = ref_pc + ib; end
      M_BGE:  begin wr = 1'b0; if ($signed(a) >= $signed(b)) nxt = ref_pc + ib; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) ref_x[rd] = wv;
    ref_pc = nxt;
  endtask

  // ---------------- helpers ----------------
  task automatic load_prog();
    logic [31:0] w;
    for (int i = 0; i < IW; i++) begin
      w = (i < prog.size()) ? prog[i] : NOP;
      dut.imem_u.ROM[i] = w;
      ref_rom[i] = w;
    end
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    load_prog();
    ref_pc = 32'h0;
    for (int i = 0; i < 32; i++) ref_x[i] = 32'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rx(input int i);
    return dut.reg_file_u.register[i];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, " pc"}, dut.program_counter_u.pc_out, ref_pc);
    for (int i = 0; i < 32; i++) chk($sformatf("%s x%0d", tag, i), rx(i), ref_x[i]);
  endtask

  task automatic run_model(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      ref_step();
      check_state(tag);
    end
  endtask

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  bf [4];
    logic [31:0] t;
    int off;
    rd = rreg(); rs1 = rreg(); rs2 = rreg();
    bf = '{3'd0, 3'd1, 3'd4, 3'd5};
    off = (int'($urandom_range(0, 16)) - 8) * 4;
    t = $urandom;
    case ($urandom_range(0, 22))
      0:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);
      1:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);
      2:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);
      3:  return enc_r(7'h00, rs2, rs1, 3'd6, rd);
      4:  return enc_r(7'h00, rs2, rs1, 3'd4, rd);
      5:  return enc_r(7'h00, rs2, rs1, 3'd2, rd);
      6:  return enc_r(7'h00, rs2, rs1, 3'd1, rd);
      7:  return enc_r(7'h00, rs2, rs1, 3'd5, rd);
      8:  return enc_r(7'h20, rs2, rs1, 3'd5, rd);
      9:  return addi(rd, rs1, 12'($urandom));
      10: return enc_i(12'($urandom), rs1, 3'd7, rd, 7'b0010011);
      11: return enc_i(12'($urandom), rs1, 3'd6, rd, 7'b0010011);
      12: return enc_i(12'($urandom), rs1, 3'd2, rd, 7'b0010011);
      13: return lw(rd, rs1, 12'($urandom));
      14: return enc_s(12'($urandom), rs2, rs1);
      15: return enc_b(13'(off), bf[$urandom_range(0, 3)], rs1, rs2);
      16: return enc_u(20'($urandom), rd);
      17: return enc_j(21'(off), rd);
      18: return enc_i(12'($urandom_range(0, 64)), rs1, 3'd0, rd, 7'b1100111);
      19: return enc_r(7'h01, rs2, rs1, 3'd0, rd);
      20: return enc_r(7'h20, rs2, rs1, 3'd1, rd);
      21: return enc_i(12'($urandom), rs1, 3'd1, rd, 7'b0010011);
      default: begin t[6:0] = 7'b0001011; return t; end
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] u, l, s;
    reset = 1'b0;
    prog.delete();
    load_prog();
    #6;
    chk("reset pc", dut.program_counter_u.pc_out, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("reset x%0d", i), rx(i), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycles(1);
      chk($sformatf("pc step %0d", k), dut.program_counter_u.pc_out, 32'(4 * k));
    end

    // x0 discard and 32-bit wrap
    prog.delete();
    prog.push_back(addi(5'd0, 5'd0, 12'd7));
    prog.push_back(addi(5'd5, 5'd0, 12'hFFF));
    prog.push_back(addi(5'd5, 5'd5, 12'd1));
    restart();
    cycles(1); chk("x0 stays 0", rx(0), 32'h0);
    cycles(1); chk("x5 = -1", rx(5), 32'hFFFF_FFFF);
    cycles(1); chk("x5 wraps", rx(5), 32'h0);

    // branch loop
    prog.delete();
    prog.push_back(addi(5'd6, 5'd0, 12'd3));
    prog.push_back(addi(5'd6, 5'd6, 12'hFFF));
    prog.push_back(enc_b(13'h1FFC, 3'd1, 5'd6, 5'd0));
    restart();
    cycles(7);
    chk("loop x6", rx(6), 32'h0);
    chk("loop pc", dut.program_counter_u.pc_out, 32'd12);

    // jal / jalr
    prog.delete();
    prog.push_back(enc_j(21'd8, 5'd1));
    prog.push_back(NOP);
    prog.push_back(enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'b1100111));
    restart();
    cycles(1);
    chk("jal x1", rx(1), 32'd4);
    chk("jal pc", dut.program_counter_u.pc_out, 32'd8);
    cycles(1);
    chk("jalr pc", dut.program_counter_u.pc_out, 32'd4);
    chk("jalr x0", rx(0), 32'h0);

    // mul encoding
    prog.delete();
    prog.push_back(addi(5'd1, 5'd0, 12'd5));
    prog.push_back(addi(5'd2, 5'd0, 12'd6));
    prog.push_back(addi(5'd7, 5'd0, 12'd9));
    prog.push_back(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd7));
    restart();
    cycles(4);
    chk("mul x7", rx(7), EXP_MUL);
    chk("mul pc", dut.program_counter_u.pc_out, 32'd16);

    // RAM preload through stores, survives reset
    prog.delete();
    prog.push_back(addi(5'd10, 5'd0, 12'd5));  prog.push_back(enc_s(12'd16, 5'd10, 5'd0));
    prog.push_back(addi(5'd10, 5'd0, 12'd6));  prog.push_back(enc_s(12'd20, 5'd10, 5'd0));
    prog.push_back(addi(5'd10, 5'd0, 12'd3));  prog.push_back(enc_s(12'd24, 5'd10, 5'd0));
    prog.push_back(addi(5'd10, 5'd0, 12'h77)); prog.push_back(enc_s(12'd32, 5'd10, 5'd0));
    restart();
    cycles(8);
    prog.delete();
    prog.push_back(lw(5'd1, 5'd0, 12'd16));
    prog.push_back(lw(5'd2, 5'd0, 12'd20));
    prog.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    prog.push_back(enc_r(7'h20, 5'd2, 5'd3, 3'd0, 5'd4));
    prog.push_back(enc_s(12'd28, 5'd3, 5'd0));
    restart();
    cycles(5);
    chk("lw x1", rx(1), 32'd5);
    chk("lw x2", rx(2), 32'd6);
    chk("add x3", rx(3), 32'd11);
    chk("sub x4", rx(4), 32'd5);
    chk("sw RAM7", dut.dmem_u.RAM[7], 32'd11);
    chk("kept RAM6", dut.dmem_u.RAM[6], 32'd3);

    // asynchronous reset abandons the in-flight store
    prog.delete();
    prog.push_back(addi(5'd9, 5'd0, 12'd1));
    prog.push_back(addi(5'd9, 5'd9, 12'd1));
    prog.push_back(addi(5'd9, 5'd9, 12'd1));
    prog.push_back(enc_s(12'd32, 5'd9, 5'd0));
    restart();
    cycles(3);
    chk("pre-reset x9", rx(9), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("async pc", dut.program_counter_u.pc_out, 32'h0);
    chk("async x9", rx(9), 32'h0);
    cycles(1);
    chk("abandoned sw", dut.dmem_u.RAM[8], 32'h77);
    chk("held pc", dut.program_counter_u.pc_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cycles(1);
    chk("restart pc", dut.program_counter_u.pc_out, 32'd4);

    // fill all of RAM through the CPU, then random programs
    for (int i = 0; i < DW; i++) ref_mem[i] = 32'h0;
    u = $urandom; l = $urandom; s = $urandom;
    prog.delete();
    prog.push_back(enc_u(u[19:0], 5'd10));
    prog.push_back(addi(5'd10, 5'd10, l[11:0]));
    prog.push_back(addi(5'd11, 5'd0, 12'd0));
    prog.push_back(addi(5'd12, 5'd0, 12'd256));
    prog.push_back(enc_s(12'd0, 5'd10, 5'd11));
    prog.push_back(addi(5'd10, 5'd10, s[11:0]));
    prog.push_back(addi(5'd11, 5'd11, 12'd4));
    prog.push_back(enc_b(13'h1FF4, 3'd1, 5'd11, 5'd12));
    prog.push_back(enc_j(21'd0, 5'd0));
    restart();
    run_model(262, "fill");
    for (int i = 0; i < DW; i++) chk($sformatf("fill RAM%0d", i), dut.dmem_u.RAM[i], ref_mem[i]);

    for (int r = 0; r < 5; r++) begin
      prog.delete();
      for (int i = 0; i < IW; i++) prog.push_back(rand_ins());
      restart();
      run_model(80, $sformatf("rand%0d", r));
      for (int i = 0; i < DW; i++) chk($sformatf("rand%0d RAM%0d", r, i), dut.dmem_u.RAM[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
